// File: rtl/cpu_mon_pkg.sv
// cpu_mon_pkg: shared state encoding, halt encodings and halt decode helper
package cpu_mon_pkg;
  typedef enum logic [2:0] {RUN, DRAIN, READ, WAIT, PRESENT, DONE} state_t;
  localparam logic [15:0] HALT_OP0_DEF = 16'hE000;
  localparam logic [15:0] HALT_OP1_DEF = 16'hE7FF;
  function automatic logic is_halt(input logic [15:0] instr, input logic [15:0] op0, input logic [15:0] op1);
    return instr == op0 || instr == op1;
  endfunction
endpackage

// File: rtl/cpu_mon_dump_seq.sv
// cpu_mon_dump_seq: read/wait/present sequencer streaming a memory window
import cpu_mon_pkg::*;
module cpu_mon_dump_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_COUNT = 1,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              fin
);
  localparam int IDX_W = $clog2(DUMP_COUNT) + 1;
  state_t st;
  logic [IDX_W-1:0] idx;
  logic [ADDR_W-1:0] addr;
  logic last, skip;
  assign last = idx == IDX_W'(DUMP_COUNT - 1);
  assign addr = ADDR_W'(DUMP_BASE) + ADDR_W'(idx);
  assign skip = SKIP_ZERO != 0 && mem_rd_data == '0;
  assign mem_rd_en = st == READ;
  assign mem_addr = mem_rd_en ? addr : '0;
  assign dump_valid = st == PRESENT;
  assign fin = (st == WAIT && skip && last) || (st == PRESENT && dump_ready && last);
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= RUN;
      idx <= '0;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      case (st)
        RUN: if (start) begin
          st <= READ;
          idx <= '0;
        end
        READ: st <= WAIT;
        WAIT: begin
          dump_addr <= addr;
          dump_data <= mem_rd_data;
          st <= !skip ? PRESENT : last ? RUN : READ;
          if (skip && !last) idx <= idx + 1'b1;
        end
        PRESENT: if (dump_ready) begin
          st <= last ? RUN : READ;
          if (!last) idx <= idx + 1'b1;
        end
        default: st <= RUN;
      endcase
    end
  end
endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: halt detect, watchdog and pipeline drain ahead of a data-memory dump
import cpu_mon_pkg::*;
module cpu_run_monitor #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [INSTR_W-1:0] HALT_OP0 = HALT_OP0_DEF,
  parameter logic [INSTR_W-1:0] HALT_OP1 = HALT_OP1_DEF,
  parameter int DRAIN_CYCLES = 10,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_COUNT = 1,
  parameter int SKIP_ZERO = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               cpu_hold,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [ADDR_W-1:0]  dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               done,
  output logic               timed_out,
  output logic [CNT_W-1:0]   cycle_count
);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 2);
  state_t state;
  logic [DC_W-1:0] drain_cnt;
  logic halt, tmo, start, fin;
  assign halt = instr_valid && is_halt(instr, HALT_OP0, HALT_OP1);
  assign tmo = TIMEOUT_CYCLES != 0 && cycle_count == CNT_W'(TIMEOUT_CYCLES - 1);
  // DRAIN lasts exactly DRAIN_CYCLES cycles, so leave it as the counter reaches 1
  assign start = (state == RUN && (halt || tmo) && DRAIN_CYCLES == 0) || (state == DRAIN && drain_cnt == DC_W'(1));
  assign cpu_hold = state == READ || state == DONE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      drain_cnt <= '0;
      timed_out <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          if (halt || tmo) begin
            state <= DRAIN_CYCLES == 0 ? READ : DRAIN;
            drain_cnt <= DC_W'(DRAIN_CYCLES);
            timed_out <= !halt;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DC_W'(1)) state <= READ;
        end
        READ: if (fin) state <= DONE;
        default: ;
      endcase
    end
  end
  cpu_mon_dump_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMP_BASE(DUMP_BASE),
    .DUMP_COUNT(DUMP_COUNT), .SKIP_ZERO(SKIP_ZERO)
  ) u_seq (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .fin(fin)
  );
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed checks of four differently configured monitors
module tb_cpu_run_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn[4], iv[4], rdy[4], hold[4], rd_en[4], dv[4], dn[4], to[4];
  logic [15:0] ins[4], maddr[4], md[4], daddr[4], ddata[4];
  logic [31:0] cc[4];
  int vectors = 0, miscompares = 0;
  int n;
  logic [15:0] wa[8], wd[8], ea;

  cpu_run_monitor u0 (
    .clk(clk), .reset(rstn[0]), .instr(ins[0]), .instr_valid(iv[0]), .cpu_hold(hold[0]),
    .mem_rd_en(rd_en[0]), .mem_addr(maddr[0]), .mem_rd_data(md[0]), .dump_valid(dv[0]),
    .dump_ready(rdy[0]), .dump_addr(daddr[0]), .dump_data(ddata[0]), .done(dn[0]),
    .timed_out(to[0]), .cycle_count(cc[0]));
  cpu_run_monitor #(.DRAIN_CYCLES(0), .DUMP_COUNT(8), .SKIP_ZERO(1)) u1 (
    .clk(clk), .reset(rstn[1]), .instr(ins[1]), .instr_valid(iv[1]), .cpu_hold(hold[1]),
    .mem_rd_en(rd_en[1]), .mem_addr(maddr[1]), .mem_rd_data(md[1]), .dump_valid(dv[1]),
    .dump_ready(rdy[1]), .dump_addr(daddr[1]), .dump_data(ddata[1]), .done(dn[1]),
    .timed_out(to[1]), .cycle_count(cc[1]));
  cpu_run_monitor #(.DUMP_BASE(16'hFFFE), .DUMP_COUNT(4), .DRAIN_CYCLES(2)) u2 (
    .clk(clk), .reset(rstn[2]), .instr(ins[2]), .instr_valid(iv[2]), .cpu_hold(hold[2]),
    .mem_rd_en(rd_en[2]), .mem_addr(maddr[2]), .mem_rd_data(md[2]), .dump_valid(dv[2]),
    .dump_ready(rdy[2]), .dump_addr(daddr[2]), .dump_data(ddata[2]), .done(dn[2]),
    .timed_out(to[2]), .cycle_count(cc[2]));
  cpu_run_monitor #(.TIMEOUT_CYCLES(50), .DRAIN_CYCLES(3)) u3 (
    .clk(clk), .reset(rstn[3]), .instr(ins[3]), .instr_valid(iv[3]), .cpu_hold(hold[3]),
    .mem_rd_en(rd_en[3]), .mem_addr(maddr[3]), .mem_rd_data(md[3]), .dump_valid(dv[3]),
    .dump_ready(rdy[3]), .dump_addr(daddr[3]), .dump_data(ddata[3]), .done(dn[3]),
    .timed_out(to[3]), .cycle_count(cc[3]));

  // Memory models return data one cycle after the strobe and junk otherwise
  always_ff @(posedge clk) begin
    md[0] <= !rd_en[0] ? 16'hDEAD : maddr[0] == 16'h0 ? 16'hBEEF : 16'h0;
    md[1] <= !rd_en[1] ? 16'hDEAD : maddr[1] == 16'd2 ? 16'h1234 : maddr[1] == 16'd5 ? 16'h00FF : 16'h0;
    md[2] <= !rd_en[2] ? 16'hDEAD : maddr[2] ^ 16'hA5A5;
    md[3] <= !rd_en[3] ? 16'hDEAD : maddr[3] == 16'h0 ? 16'h0042 : 16'h0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  initial begin
    #300000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rstn[i] = 1'b0; iv[i] = 1'b0; rdy[i] = 1'b0; ins[i] = 16'h0;
    end
    steps(2);
    chk("reset flags", {hold[0], rd_en[0], dv[0], dn[0], to[0]}, 64'h0);
    chk("reset addr/data", {maddr[0], daddr[0], ddata[0]}, 64'h0);
    chk("reset cycle_count", cc[0], 64'h0);

    // Normal halt at cycle 20, drain 10
    rstn[0] = 1'b1;
    steps(20);
    chk("A count@20", cc[0], 64'd20);
    ins[0] = 16'hE000; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    chk("A count@21", cc[0], 64'd21);
    steps(9);
    chk("A idle@30", {rd_en[0], hold[0]}, 64'h0);
    step();
    chk("A read@31", {rd_en[0], hold[0], maddr[0]}, {46'h0, 2'b11, 16'h0});
    step();
    chk("A wait@32", {rd_en[0], dv[0]}, 64'h0);
    step();
    chk("A present@33", {dv[0], daddr[0], ddata[0]}, {31'h0, 1'b1, 16'h0, 16'hBEEF});
    step();
    chk("A hold valid@34", {dv[0], ddata[0]}, {47'h0, 1'b1, 16'hBEEF});
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;
    chk("A done", {dn[0], dv[0], hold[0], to[0]}, 64'b1010);
    chk("A count frozen", cc[0], 64'd21);
    ins[0] = 16'hE7FF; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    steps(3);
    chk("A sticky done", {dn[0], rd_en[0], dv[0]}, 64'b100);

    // Reset in the middle of PRESENT, then a fresh dump
    rstn[0] = 1'b0;
    step();
    rstn[0] = 1'b1;
    ins[0] = 16'hE000; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    steps(12);
    chk("R present@13", dv[0], 64'h1);
    rstn[0] = 1'b0;
    step();
    chk("R abort flags", {hold[0], rd_en[0], dv[0], dn[0], to[0]}, 64'h0);
    chk("R abort data", {maddr[0], daddr[0], ddata[0], cc[0]}, 64'h0);
    rstn[0] = 1'b1;
    ins[0] = 16'hE000; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    steps(10);
    chk("R reread@11", {rd_en[0], maddr[0]}, {47'h0, 1'b1, 16'h0});
    steps(2);
    chk("R present again", {dv[0], daddr[0], ddata[0]}, {31'h0, 1'b1, 16'h0, 16'hBEEF});
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;
    chk("R done", dn[0], 64'h1);

    // Alternate encoding, bubbles, zero drain, skip-zero window
    rstn[1] = 1'b1;
    steps(3);
    ins[1] = 16'hE7FF; iv[1] = 1'b0;
    step();
    chk("B bubble ignored", {cc[1], 30'h0, hold[1], rd_en[1]}, {32'd4, 32'h0});
    iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    chk("B read next cycle", {rd_en[1], hold[1], maddr[1]}, {46'h0, 2'b11, 16'h0});
    rdy[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && !dn[1]; i++) begin
      step();
      if (dv[1] && n < 8) begin
        wa[n] = daddr[1]; wd[n] = ddata[1]; n++;
      end
    end
    chk("B word count", n, 64'd2);
    chk("B word0", {wa[0], wd[0]}, {32'h0, 16'd2, 16'h1234});
    chk("B word1", {wa[1], wd[1]}, {32'h0, 16'd5, 16'h00FF});
    chk("B done", {dn[1], dv[1], to[1]}, 64'b100);

    // Backpressure with address wrap
    rstn[2] = 1'b1;
    ins[2] = 16'hE000; iv[2] = 1'b1;
    step();
    iv[2] = 1'b0;
    for (int w = 0; w < 4; w++) begin
      ea = 16'hFFFE + 16'(w);
      for (int i = 0; i < 20 && !dv[2]; i++) step();
      chk("C word", {dv[2], daddr[2], ddata[2]}, {31'h0, 1'b1, ea, ea ^ 16'hA5A5});
      for (int k = 0; k < 5; k++) begin
        step();
        chk("C stable", {dv[2], daddr[2], ddata[2]}, {31'h0, 1'b1, ea, ea ^ 16'hA5A5});
      end
      rdy[2] = 1'b1;
      step();
      rdy[2] = 1'b0;
    end
    chk("C done", {dn[2], dv[2], hold[2]}, 64'b101);

    // Watchdog fires at count 49
    rstn[3] = 1'b1;
    rdy[3] = 1'b1;
    steps(49);
    chk("D before timeout", {cc[3], 31'h0, to[3]}, {32'd49, 32'h0});
    step();
    chk("D timed out", {cc[3], 31'h0, to[3]}, {32'd50, 32'h1});
    steps(3);
    chk("D read@53", {rd_en[3], maddr[3]}, {47'h0, 1'b1, 16'h0});
    steps(2);
    chk("D present", {dv[3], ddata[3]}, {47'h0, 1'b1, 16'h0042});
    step();
    chk("D done", {dn[3], to[3]}, 64'b11);

    // Halt on the timeout cycle wins
    rstn[3] = 1'b0;
    step();
    rstn[3] = 1'b1;
    steps(49);
    chk("E count@49", cc[3], 64'd49);
    ins[3] = 16'hE000; iv[3] = 1'b1;
    step();
    iv[3] = 1'b0;
    chk("E halt wins", {cc[3], 31'h0, to[3]}, {32'd50, 32'h0});
    steps(6);
    chk("E done", {dn[3], to[3]}, 64'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
